// File: rtl/frog_player_fsm.sv
// ============================================================================
// Module   : frog_player_fsm
// Purpose  : Frogger player controller. Tracks position, lives, score and
//            home occupancy, and sequences death, respawn and game over.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frog_player_fsm #(
  parameter int c_GRID_W     = 14,
  parameter int c_GRID_H     = 15,
  parameter int c_START_X    = 10,
  parameter int c_START_Y    = 14,
  parameter int c_LIVES      = 3,
  parameter int c_NUM_HOMES  = 5,
  parameter int c_DRIFT_DIV  = 39000000,
  parameter int c_DEATH_HOLD = 25000000,
  parameter int c_EDGE_WRAP  = 0,
  parameter int c_PAD_CODE   = 4,
  parameter int c_WATER_CODE = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_New_Game,
  input  logic        i_Game_Active,
  input  logic        i_Up_Mvt,
  input  logic        i_Down_Mvt,
  input  logic        i_Left_Mvt,
  input  logic        i_Right_Mvt,
  input  logic        i_Collided,
  input  logic [3:0]  i_Tile_Code,
  input  logic        i_On_Log,
  input  logic        i_Log_Dir,
  output logic [5:0]  o_Frogger_X,
  output logic [5:0]  o_Frogger_Y,
  output logic [6:0]  o_Score,
  output logic [2:0]  o_Lives,
  output logic [63:0] o_Home_Mask,
  output logic [1:0]  o_State,
  output logic        o_Death_Pulse,
  output logic        o_Level_Up
);

  localparam int c_DRIFT_W = (c_DRIFT_DIV > 1) ? $clog2(c_DRIFT_DIV) : 1;
  localparam int c_HOLD_W  = (c_DEATH_HOLD > 1) ? $clog2(c_DEATH_HOLD) : 1;

  localparam logic [c_DRIFT_W-1:0] c_DRIFT_LAST = c_DRIFT_W'(c_DRIFT_DIV - 1);
  localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(c_DEATH_HOLD - 1);
  localparam logic [5:0] c_X_MAX   = 6'(c_GRID_W - 1);
  localparam logic [5:0] c_Y_MAX   = 6'(c_GRID_H - 1);
  localparam logic [5:0] c_X0      = 6'(c_START_X);
  localparam logic [5:0] c_Y0      = 6'(c_START_Y);
  localparam logic [2:0] c_LIVES0  = 3'(c_LIVES);
  localparam logic [6:0] c_HOMES   = 7'(c_NUM_HOMES);
  localparam logic [3:0] c_PAD     = 4'(c_PAD_CODE);
  localparam logic [3:0] c_WATER   = 4'(c_WATER_CODE);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ALIVE     = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t                r_state;
  logic [5:0]            r_x, r_y;
  logic [6:0]            r_score, r_homes;
  logic [2:0]            r_lives;
  logic [63:0]           r_mask;
  logic [c_DRIFT_W-1:0]  r_drift_cnt;
  logic [c_HOLD_W-1:0]   r_hold_cnt;
  logic                  r_death_pulse, r_level_up;
  logic                  r_up_q, r_down_q, r_left_q, r_right_q;

  logic       w_up_e, w_down_e, w_left_e, w_right_e, w_move;
  logic       w_drift_term, w_drift_step, w_at_edge, w_edge_death;
  logic       w_at_home, w_home_ok, w_die;
  logic [5:0] w_x_mv, w_y_mv, w_drift_x;
  logic [6:0] w_score_inc, w_homes_inc;

  assign w_up_e    = i_Up_Mvt    & ~r_up_q;
  assign w_down_e  = i_Down_Mvt  & ~r_down_q;
  assign w_left_e  = i_Left_Mvt  & ~r_left_q;
  assign w_right_e = i_Right_Mvt & ~r_right_q;
  assign w_move    = w_up_e | w_down_e | w_left_e | w_right_e;

  // A button press defers a due drift step by one cycle instead of dropping either.
  assign w_drift_term = i_On_Log && (r_drift_cnt == c_DRIFT_LAST);
  assign w_drift_step = w_drift_term && !w_move;
  assign w_at_edge    = i_Log_Dir ? (r_x == c_X_MAX) : (r_x == 6'd0);
  assign w_edge_death = w_drift_step && w_at_edge && (c_EDGE_WRAP == 0);
  assign w_drift_x    = i_Log_Dir ? ((r_x == c_X_MAX) ? 6'd0 : r_x + 6'd1)
                                  : ((r_x == 6'd0) ? c_X_MAX : r_x - 6'd1);

  assign w_at_home = (r_y == 6'd0);
  assign w_home_ok = w_at_home && (i_Tile_Code == c_PAD) && !r_mask[r_x];
  assign w_die     = i_Collided || ((i_Tile_Code == c_WATER) && !i_On_Log)
                     || w_edge_death || (w_at_home && !w_home_ok);

  assign w_score_inc = (r_score == 7'd127) ? r_score : r_score + 7'd1;
  assign w_homes_inc = r_homes + 7'd1;

  always_comb begin
    w_x_mv = r_x;
    w_y_mv = r_y;
    if (w_up_e)
      w_y_mv = (r_y == 6'd0) ? r_y : r_y - 6'd1;
    else if (w_down_e)
      w_y_mv = (r_y == c_Y_MAX) ? r_y : r_y + 6'd1;
    else if (w_left_e)
      w_x_mv = (r_x == 6'd0) ? r_x : r_x - 6'd1;
    else if (w_right_e)
      w_x_mv = (r_x == c_X_MAX) ? r_x : r_x + 6'd1;
  end

  always_ff @(posedge i_Clk) begin
    r_up_q        <= i_Up_Mvt;
    r_down_q      <= i_Down_Mvt;
    r_left_q      <= i_Left_Mvt;
    r_right_q     <= i_Right_Mvt;
    r_death_pulse <= 1'b0;
    r_level_up    <= 1'b0;
    if (!i_Rst_L) begin
      r_state     <= ST_IDLE;
      r_x         <= c_X0;
      r_y         <= c_Y0;
      r_score     <= 7'd0;
      r_lives     <= c_LIVES0;
      r_mask      <= '0;
      r_homes     <= 7'd0;
      r_drift_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAME_OVER: begin
          if (i_New_Game) begin
            r_state     <= ST_ALIVE;
            r_x         <= c_X0;
            r_y         <= c_Y0;
            r_score     <= 7'd0;
            r_lives     <= c_LIVES0;
            r_mask      <= '0;
            r_homes     <= 7'd0;
            r_drift_cnt <= '0;
          end
        end
        ST_ALIVE: begin
          if (i_Game_Active) begin
            if (w_die) begin
              r_lives       <= r_lives - 3'd1;
              r_death_pulse <= 1'b1;
              r_hold_cnt    <= '0;
              r_state       <= ST_DYING;
            end else if (w_at_home) begin
              r_score     <= w_score_inc;
              r_mask[r_x] <= 1'b1;
              r_homes     <= w_homes_inc;
              r_x         <= c_X0;
              r_y         <= c_Y0;
              r_drift_cnt <= '0;
              if (w_homes_inc == c_HOMES) begin
                r_level_up <= 1'b1;
                r_mask     <= '0;
                r_homes    <= 7'd0;
              end
            end else begin
              r_x <= w_x_mv;
              r_y <= w_y_mv;
              if (!i_On_Log) begin
                r_drift_cnt <= '0;
              end else if (w_drift_term) begin
                if (w_drift_step) begin
                  r_x         <= w_drift_x;
                  r_drift_cnt <= '0;
                end
              end else begin
                r_drift_cnt <= r_drift_cnt + 1'b1;
              end
            end
          end
        end
        ST_DYING: begin
          if (i_Game_Active) begin
            if (r_hold_cnt == c_HOLD_LAST) begin
              if (r_lives == 3'd0) begin
                r_state <= ST_GAME_OVER;
              end else begin
                r_state     <= ST_ALIVE;
                r_x         <= c_X0;
                r_y         <= c_Y0;
                r_drift_cnt <= '0;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_Frogger_X   = r_x;
  assign o_Frogger_Y   = r_y;
  assign o_Score       = r_score;
  assign o_Lives       = r_lives;
  assign o_Home_Mask   = r_mask;
  assign o_State       = r_state;
  assign o_Death_Pulse = r_death_pulse;
  assign o_Level_Up    = r_level_up;

endmodule

`default_nettype wire

// File: tb/tb_frog_player_fsm.sv
// ============================================================================
// Module   : tb_frog_player_fsm
// Purpose  : Directed scoreboard bench; two instances share stimulus (A: no
//            wrap, 3 lives, 2 homes; B: wrap, 1 life, 5 homes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frog_player_fsm;

  logic clk = 1'b0;
  logic rst_l, new_game, active, up, down, left, right, collided, on_log, log_dir;
  logic [3:0] tile;

  logic [5:0]  a_x, a_y, b_x, b_y;
  logic [6:0]  a_sc, b_sc;
  logic [2:0]  a_lv, b_lv;
  logic [63:0] a_mask, b_mask;
  logic [1:0]  a_st, b_st;
  logic        a_dp, b_dp, a_lu, b_lu;

  always #5 clk = ~clk;

  frog_player_fsm #(
    .c_DRIFT_DIV(4), .c_DEATH_HOLD(8), .c_EDGE_WRAP(0), .c_LIVES(3), .c_NUM_HOMES(2)
  ) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_New_Game(new_game), .i_Game_Active(active),
    .i_Up_Mvt(up), .i_Down_Mvt(down), .i_Left_Mvt(left), .i_Right_Mvt(right),
    .i_Collided(collided), .i_Tile_Code(tile), .i_On_Log(on_log), .i_Log_Dir(log_dir),
    .o_Frogger_X(a_x), .o_Frogger_Y(a_y), .o_Score(a_sc), .o_Lives(a_lv),
    .o_Home_Mask(a_mask), .o_State(a_st), .o_Death_Pulse(a_dp), .o_Level_Up(a_lu)
  );

  frog_player_fsm #(
    .c_DRIFT_DIV(4), .c_DEATH_HOLD(8), .c_EDGE_WRAP(1), .c_LIVES(1), .c_NUM_HOMES(5)
  ) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_New_Game(new_game), .i_Game_Active(active),
    .i_Up_Mvt(up), .i_Down_Mvt(down), .i_Left_Mvt(left), .i_Right_Mvt(right),
    .i_Collided(collided), .i_Tile_Code(tile), .i_On_Log(on_log), .i_Log_Dir(log_dir),
    .o_Frogger_X(b_x), .o_Frogger_Y(b_y), .o_Score(b_sc), .o_Lives(b_lv),
    .o_Home_Mask(b_mask), .o_State(b_st), .o_Death_Pulse(b_dp), .o_Level_Up(b_lu)
  );

  localparam int X = 0, Y = 1, SC = 2, LV = 3, MK = 4, ST = 5, DP = 6, LU = 7, B = 8;
  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  typedef struct {
    string       tag;
    int          sig;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic logic [63:0] obs(int sig);
    case (sig)
      X:      return 64'(a_x);
      Y:      return 64'(a_y);
      SC:     return 64'(a_sc);
      LV:     return 64'(a_lv);
      MK:     return a_mask;
      ST:     return 64'(a_st);
      DP:     return 64'(a_dp);
      LU:     return 64'(a_lu);
      B+X:    return 64'(b_x);
      B+Y:    return 64'(b_y);
      B+SC:   return 64'(b_sc);
      B+LV:   return 64'(b_lv);
      B+MK:   return b_mask;
      B+ST:   return 64'(b_st);
      B+DP:   return 64'(b_dp);
      B+LU:   return 64'(b_lu);
      default: return 64'hDEAD;
    endcase
  endfunction

  task automatic expv(string tag, int sig, logic [63:0] v);
    sb.push_back('{tag, sig, v});
  endtask

  task automatic check_all();
    exp_t e;
    logic [63:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      n_total++;
      assert (o === e.exp) begin
        n_pass++;
      end else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(int d, int n);
    for (int i = 0; i < n; i++) begin
      case (d)
        UP:      up = 1'b1;
        DOWN:    down = 1'b1;
        LEFT:    left = 1'b1;
        default: right = 1'b1;
      endcase
      tick();
      up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // Walks from the spawn column to (10-dx, 0); the next tick evaluates the home.
  task automatic reach_home(int dx);
    press(LEFT, dx);
    press(UP, 13);
    up = 1'b1;
    tick();
    up = 1'b0;
    tile = 4'd4;
  endtask

  initial begin
    rst_l = 1'b0; new_game = 1'b0; active = 1'b1; collided = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    tile = 4'd0; on_log = 1'b0; log_dir = 1'b0;

    // Reset values
    do_reset();
    expv("rst_state", ST, 0); expv("rst_x", X, 10); expv("rst_y", Y, 14);
    expv("rst_score", SC, 0); expv("rst_lives", LV, 3); expv("rst_mask", MK, 0);
    expv("rst_dp", DP, 0); expv("rst_lu", LU, 0); expv("rst_b_lives", B+LV, 1);
    check_all();

    // New game, clamps, first home
    new_game = 1'b1;
    expv("ng_state", ST, 1); expv("ng_x", X, 10); expv("ng_y", Y, 14);
    expv("ng_lives", LV, 3); expv("ng_score", SC, 0);
    tick(); check_all();
    new_game = 1'b0;
    expv("down_clamp_y", Y, 14);
    press(DOWN, 1); check_all();
    expv("left_clamp_x", X, 0);
    press(LEFT, 11); check_all();
    expv("up13_y", Y, 1);
    press(UP, 13); check_all();
    up = 1'b1;
    expv("up14_y", Y, 0);
    tick(); check_all();
    up = 1'b0; tile = 4'd4;
    expv("home0_score", SC, 1); expv("home0_mask", MK, 64'h1);
    expv("home0_x", X, 10); expv("home0_y", Y, 14); expv("home0_lu", LU, 0);
    expv("home0_b_score", B+SC, 1);
    tick(); check_all();
    tile = 4'd0;

    // Drift right, edge death vs wrap, paused death hold
    do_reset(); start_game();
    expv("right2_x", X, 12);
    press(RIGHT, 2); check_all();
    on_log = 1'b1; log_dir = 1'b1; tile = 4'd2;
    repeat (3) tick();
    expv("drift_early_x", X, 12);
    check_all();
    expv("drift_x", X, 13); expv("drift_b_x", B+X, 13);
    tick(); check_all();
    repeat (3) tick();
    expv("edge_dp", DP, 1); expv("edge_lives", LV, 2); expv("edge_state", ST, 2);
    expv("edge_x", X, 13); expv("wrap_b_x", B+X, 0); expv("wrap_b_state", B+ST, 1);
    expv("wrap_b_dp", B+DP, 0);
    tick(); check_all();
    on_log = 1'b0; tile = 4'd0;
    expv("dp_one_cycle", DP, 0); expv("dying_e1", ST, 2);
    tick(); check_all();
    repeat (6) tick();
    expv("dying_e7", ST, 2);
    check_all();
    active = 1'b0;
    repeat (3) tick();
    expv("dying_paused", ST, 2);
    check_all();
    active = 1'b1;
    expv("respawn_state", ST, 1); expv("respawn_x", X, 10); expv("respawn_y", Y, 14);
    expv("respawn_lives", LV, 2);
    tick(); check_all();

    // Home at 3, repeat at filled home, game over on B
    do_reset(); start_game();
    reach_home(7);
    expv("home3_score", SC, 1); expv("home3_mask", MK, 64'h8); expv("home3_x", X, 10);
    expv("home3_y", Y, 14); expv("home3_b_mask", B+MK, 64'h8);
    tick(); check_all();
    tile = 4'd0;
    reach_home(7);
    expv("filled_dp", DP, 1); expv("filled_lives", LV, 2); expv("filled_score", SC, 1);
    expv("filled_state", ST, 2); expv("filled_x", X, 3); expv("filled_y", Y, 0);
    expv("filled_b_state", B+ST, 2); expv("filled_b_lives", B+LV, 0);
    tick(); check_all();
    tile = 4'd0;
    repeat (7) tick();
    expv("b_dying_e7", B+ST, 2);
    check_all();
    expv("b_gameover", B+ST, 3); expv("b_go_x", B+X, 3); expv("b_go_y", B+Y, 0);
    expv("a_respawn", ST, 1);
    tick(); check_all();
    new_game = 1'b1;
    expv("b_ng_state", B+ST, 1); expv("b_ng_lives", B+LV, 1); expv("b_ng_score", B+SC, 0);
    expv("b_ng_mask", B+MK, 0); expv("b_ng_x", B+X, 10); expv("b_ng_y", B+Y, 14);
    expv("a_ng_ignored_sc", SC, 1); expv("a_ng_ignored_lv", LV, 2); expv("a_ng_ignored_st", ST, 1);
    tick(); check_all();
    new_game = 1'b0;
    collided = 1'b1;
    expv("coll_lives", LV, 1); expv("coll_dp", DP, 1); expv("coll_state", ST, 2);
    expv("coll_b_state", B+ST, 2); expv("coll_b_lives", B+LV, 0); expv("coll_b_dp", B+DP, 1);
    tick(); check_all();
    collided = 1'b0;
    rst_l = 1'b0;
    expv("midrst_state", ST, 0); expv("midrst_dp", DP, 0); expv("midrst_lives", LV, 3);
    expv("midrst_x", X, 10);
    tick(); check_all();
    rst_l = 1'b1;

    // Level complete on A after homes at 1 and 5
    do_reset(); start_game();
    reach_home(9);
    expv("lvl_h1_score", SC, 1); expv("lvl_h1_mask", MK, 64'h2); expv("lvl_h1_lu", LU, 0);
    tick(); check_all();
    tile = 4'd0;
    reach_home(5);
    expv("lvl_lu", LU, 1); expv("lvl_mask", MK, 0); expv("lvl_score", SC, 2);
    expv("lvl_b_mask", B+MK, 64'h22); expv("lvl_b_score", B+SC, 2); expv("lvl_b_lu", B+LU, 0);
    tick(); check_all();
    tile = 4'd0;
    expv("lvl_lu_one_cycle", LU, 0);
    tick(); check_all();

    // Button move and drift step collide: neither is lost
    do_reset(); start_game();
    expv("left5_x", X, 5);
    press(LEFT, 5); check_all();
    on_log = 1'b1; log_dir = 1'b0; tile = 4'd2;
    repeat (3) tick();
    left = 1'b1;
    expv("conflict_move_x", X, 4);
    tick(); check_all();
    left = 1'b0;
    expv("conflict_drift_x", X, 3); expv("conflict_state", ST, 1);
    tick(); check_all();
    on_log = 1'b0; tile = 4'd0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frog_player_fsm.md
Name: frog_player_fsm

Overview:
Parametrised next-generation Frogger player controller. Owns frog grid position, lives, score and filled-home tracking, and sequences death/respawn/game-over through an explicit state machine. Sits between the debounced button inputs / collision & tile lookup and the renderer / HUD. Adds bidirectional log drift, edge-death mode, home occupancy and level completion.

Parameters:
c_GRID_W, 14, playfield columns (max 64)
c_GRID_H, 15, playfield rows (max 64); row 0 = home row
c_START_X, 10, respawn column
c_START_Y, 14, respawn row
c_LIVES, 3, lives per game (1..7)
c_NUM_HOMES, 5, homes to fill for level complete
c_DRIFT_DIV, 39000000, clocks per one-tile log drift step
c_DEATH_HOLD, 25000000, clocks frozen in DYING
c_EDGE_WRAP, 0, 1 = drift wraps at edge, 0 = carried off edge is death
c_PAD_CODE, 4, tile code of lily pad
c_WATER_CODE, 2, tile code of water

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  synchronous active-low reset
i_New_Game  in  1  one-cycle start pulse
i_Game_Active  in  1  1 = run, 0 = pause
i_Up_Mvt / i_Down_Mvt / i_Left_Mvt / i_Right_Mvt  in  1 each  debounced switch levels
i_Collided  in  1  vehicle hit, level
i_Tile_Code  in  4  tile under current o_Frogger_X/Y, same cycle
i_On_Log  in  1  frog over a log
i_Log_Dir  in  1  0 = lane drifts left, 1 = right
o_Frogger_X  out  6  column
o_Frogger_Y  out  6  row
o_Score  out  7  homes reached, saturates 127
o_Lives  out  3  remaining lives
o_Home_Mask  out  64  bit n = home at column n filled (bits >= c_GRID_W are 0)
o_State  out  2  0 IDLE, 1 ALIVE, 2 DYING, 3 GAME_OVER
o_Death_Pulse  out  1  one cycle on each death
o_Level_Up  out  1  one cycle on level complete

Behaviour:
- Reset (i_Rst_L=0 at edge): X=c_START_X, Y=c_START_Y, score 0, lives c_LIVES, mask 0, homes-filled count 0, drift/hold counters 0, state IDLE, pulses 0. All switch-history regs load current input levels.
- Move = rising edge of a switch vs its registered previous value. History regs update every cycle in every state, so resume/respawn never produces spurious moves.
- IDLE/GAME_OVER: i_New_Game -> reload score 0, lives c_LIVES, mask 0, count 0, respawn position -> ALIVE. All other inputs ignored.
- ALIVE with i_Game_Active=0: everything frozen (position, counters, state); edge history still tracked.
- ALIVE with i_Game_Active=1, per-cycle priority (highest first):
  1. Death: i_Collided; or tile==c_WATER_CODE and !i_On_Log; or drift step off edge with c_EDGE_WRAP=0.
  2. Home (Y==0): tile==c_PAD_CODE and mask[X]==0 -> score+1 (sat), mask[X]<=1, count+1, respawn. If count reaches c_NUM_HOMES: o_Level_Up pulse, mask<=0, count<=0. Otherwise (not pad or already filled) -> death.
  3. Drift: while i_On_Log, counter increments; at c_DRIFT_DIV-1, X steps per i_Log_Dir and counter clears. Wrap: 0 -> c_GRID_W-1, c_GRID_W-1 -> 0. !i_On_Log clears counter.
  4. Button move: one axis per cycle, priority Up>Down>Left>Right; clamped to [0,c_GRID_W-1] x [0,c_GRID_H-1].
  - Drift step and button move in same cycle: move applied, drift counter holds at terminal and steps next cycle. No press lost.
- Death: lives-1, o_Death_Pulse, hold counter 0, -> DYING. Position frozen at death tile.
- DYING: inputs ignored; i_Game_Active=0 pauses hold counter. After c_DEATH_HOLD cycles: lives==0 -> GAME_OVER (position kept); else respawn -> ALIVE, drift counter cleared.
- i_New_Game in ALIVE/DYING ignored.
- Reset mid-DYING or mid-drift: reset values next cycle, no pulse emitted.

Test Plan:
- Reset then i_New_Game -> State=1, X=10, Y=14, Lives=3, Score=0; 14 Up edges -> Y=0 reached, 15th edge holds at 0; Down held at Y=14 stays 14.
- c_DRIFT_DIV=4, i_On_Log=1, i_Log_Dir=1, X=12 -> X=13 after 4 clocks; c_EDGE_WRAP=0 next step -> Death_Pulse, Lives=2, State=2; c_EDGE_WRAP=1 -> X=0.
- Y=0, tile=4, X=3, mask[3]=0 -> Score+1, mask[3]=1, X=10/Y=14; repeat at X=3 -> death, Lives-1, Score unchanged.
- c_NUM_HOMES=2, fill columns 1 and 5 -> Level_Up one cycle, mask=0, Score=2.
- c_DEATH_HOLD=8, c_LIVES=1, i_Collided -> State=2 for 8 clocks, then State=3; i_New_Game -> State=1, Lives=1, Score=0.
- Left edge and drift terminal same cycle (i_Log_Dir=0, X=5) -> X=4 that cycle, X=3 next cycle; i_Game_Active=0 during DYING extends hold by paused cycles.
